threewire_mc: RTL and testbench

//  Next-gen 3-wire serial master: runtime clock divider, NUM_CS chip selects,

---
 rtl/threewire_pkg.sv | 26 ++
 rtl/threewire_mc_if.sv | 36 +++
 rtl/threewire_clkgen.sv | 60 ++++++
 rtl/threewire_mc.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_threewire_mc.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/threewire_pkg.sv
// threewire_mc shared types: FSM state encoding, transfer-direction
// constants and a small elaboration-time helper.
package threewire_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SETUP,
    S_RW,
    S_ADDR,
    S_WDATA,
    S_TURN,
    S_RDATA,
    S_PARITY,
    S_HOLD
  } state_t;

  localparam logic TW_RD = 1'b0;
  localparam logic TW_WR = 1'b1;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/threewire_mc_if.sv
// Host-side register-bank bundle of threewire_mc.
// master = host (drives in_*), slave = threewire_mc (drives out_*).
interface threewire_mc_if #(
  parameter int ADDR_BITS = 9,
  parameter int DATA_BITS = 16,
  parameter int NUM_CS    = 4,
  parameter int DIV_BITS  = 8
);
  localparam int SEL_BITS = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  logic                 in_start;
  logic                 in_mode_wr;
  logic [SEL_BITS-1:0]  in_cs_sel;
  logic [ADDR_BITS-1:0] in_addr;
  logic [DATA_BITS-1:0] in_wr_data;
  logic [DIV_BITS-1:0]  in_div;
  logic [DATA_BITS-1:0] out_rd_data;
  logic                 out_busy;
  logic                 out_done;
  logic                 out_sel_err;

  modport master (
    output in_start, in_mode_wr, in_cs_sel,
    output in_addr, in_wr_data, in_div,
    input  out_rd_data, out_busy,
    input  out_done, out_sel_err
  );

  modport slave (
    input  in_start, in_mode_wr, in_cs_sel,
    input  in_addr, in_wr_data, in_div,
    output out_rd_data, out_busy,
    output out_done, out_sel_err
  );

endinterface

// File: rtl/threewire_clkgen.sv
// 3-wire bit-clock generator: half-period counter of div+1 cycles.
// Ports: en/clr from FSM, gate lets rise reach tw_clock; rise/fall strobes.
module threewire_clkgen #(
  parameter int DIV_BITS = 8
) (
  input  logic                in_clk,
  input  logic                in_rst,
  input  logic                en,
  input  logic                clr,
  input  logic                gate,
  input  logic [DIV_BITS-1:0] div,
  output logic                rise,
  output logic                fall,
  output logic                tw_clock
);

  logic [DIV_BITS-1:0] cnt_q, cnt_d;
  logic                half_q, half_d;
  logic                clk_q, clk_d;
  logic                wrap;

  // wrap at cnt==div, so all-ones div never overflows the counter
  assign wrap     = (cnt_q == div);
  assign rise     = en & wrap & ~half_q;
  assign fall     = en & wrap & half_q;
  assign tw_clock = clk_q;

  always_comb begin
    cnt_d  = cnt_q;
    half_d = half_q;
    clk_d  = clk_q;
    if (clr) begin
      cnt_d  = '0;
      half_d = 1'b0;
      clk_d  = 1'b0;
    end else if (en) begin
      if (wrap) begin
        cnt_d  = '0;
        half_d = ~half_q;
      end else begin
        cnt_d = cnt_q + DIV_BITS'(1);
      end
      if (rise && gate) clk_d = 1'b1;
      if (fall)         clk_d = 1'b0;
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      cnt_q  <= '0;
      half_q <= 1'b0;
      clk_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      half_q <= half_d;
      clk_q  <= clk_d;
    end
  end

endmodule

// File: rtl/threewire_mc.sv
// 3-wire serial master: host bundle (threewire_mc_if.slave), tw clock/cs/data
// pins. Macro THREEWIRE_MC_PARITY_EN adds a parity bit and out_parity_err.
module threewire_mc
  import threewire_pkg::*;
#(
  parameter int ADDR_BITS  = 9,
  parameter int DATA_BITS  = 16,
  parameter int NUM_CS     = 4,
  parameter int DIV_BITS   = 8,
  parameter int TURNAROUND = 1
) (
  input  logic              in_clk,
  input  logic              in_rst,
  threewire_mc_if.slave     host,
  output logic              out_tw_clock,
  output logic [NUM_CS-1:0] out_tw_cs,
  output logic              out_tw_data_o,
  output logic              out_tw_data_oe,
`ifdef THREEWIRE_MC_PARITY_EN
  output logic              out_parity_err,
`endif
  input  logic              in_tw_data_i
);

  localparam int SEL_BITS = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int CNT_BITS =
    $clog2(max3(ADDR_BITS, DATA_BITS, TURNAROUND) + 1);
`ifdef THREEWIRE_MC_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int TX_BITS  = 1 + ADDR_BITS + DATA_BITS + PAR_BITS;

  localparam logic [CNT_BITS-1:0] CNT_ADDR = CNT_BITS'(ADDR_BITS - 1);
  localparam logic [CNT_BITS-1:0] CNT_DATA = CNT_BITS'(DATA_BITS - 1);
  localparam logic [CNT_BITS-1:0] CNT_TURN = CNT_BITS'(TURNAROUND - 1);
  localparam logic [SEL_BITS:0]   CS_LIM   = (SEL_BITS + 1)'(NUM_CS);

  state_t               state_q, state_d;
  logic                 mode_q, mode_d;
  logic [DIV_BITS-1:0]  div_q, div_d;
  logic [NUM_CS-1:0]    cs_q, cs_d;
  logic [TX_BITS-1:0]   tx_q, tx_d;
  logic [DATA_BITS-1:0] rx_q, rx_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 sel_err_q, sel_err_d;
  logic                 dout_q, dout_d;
  logic                 oe_q, oe_d;
  logic [DATA_BITS-1:0] rd_data_q, rd_data_d;
`ifdef THREEWIRE_MC_PARITY_EN
  logic                 par_in_q, par_in_d;
  logic                 parity_err_q, parity_err_d;
`endif

  logic clk_en, clk_clr, clk_gate;
  logic rise, fall;
  logic sel_ok;
  logic cnt_zero;
  logic tx_msb;

  assign sel_ok   = ({1'b0, host.in_cs_sel} < CS_LIM);
  assign cnt_zero = (cnt_q == '0);
  assign tx_msb   = tx_q[TX_BITS-1];
  assign clk_en   = (state_q != S_IDLE);
  // SETUP and HOLD keep the bus clock low
  assign clk_gate = state_q inside {S_RW, S_ADDR, S_WDATA,
                                    S_TURN, S_RDATA, S_PARITY};

  threewire_clkgen #(
    .DIV_BITS (DIV_BITS)
  ) u_clkgen (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .en       (clk_en),
    .clr      (clk_clr),
    .gate     (clk_gate),
    .div      (div_q),
    .rise     (rise),
    .fall     (fall),
    .tw_clock (out_tw_clock)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    div_d     = div_q;
    cs_d      = cs_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sel_err_d = 1'b0;
    dout_d    = dout_q;
    oe_d      = oe_q;
    rd_data_d = rd_data_q;
    clk_clr   = 1'b0;
`ifdef THREEWIRE_MC_PARITY_EN
    par_in_d     = par_in_q;
    parity_err_d = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        clk_clr = 1'b1;
        if (host.in_start) begin
          if (sel_ok) begin
            state_d = S_SETUP;
            mode_d  = host.in_mode_wr;
            div_d   = host.in_div;
            cs_d    = ~(NUM_CS'(1) << host.in_cs_sel);
`ifdef THREEWIRE_MC_PARITY_EN
            tx_d    = {host.in_mode_wr, host.in_addr,
                       host.in_wr_data,
                       ^{host.in_mode_wr, host.in_addr,
                         host.in_wr_data}};
`else
            tx_d    = {host.in_mode_wr, host.in_addr,
                       host.in_wr_data};
`endif
            busy_d  = 1'b1;
            oe_d    = 1'b1;
            dout_d  = 1'b0;
          end else begin
            sel_err_d = 1'b1;
          end
        end
      end
      S_SETUP: begin
        if (fall) begin
          state_d = S_RW;
          dout_d  = tx_msb;
          tx_d    = tx_q << 1;
        end
      end
      S_RW: begin
        if (fall) begin
          state_d = S_ADDR;
          cnt_d   = CNT_ADDR;
          dout_d  = tx_msb;
          tx_d    = tx_q << 1;
        end
      end
      S_ADDR: begin
        if (fall) begin
          if (!cnt_zero) begin
            cnt_d  = cnt_q - CNT_BITS'(1);
            dout_d = tx_msb;
            tx_d   = tx_q << 1;
          end else if (mode_q == TW_WR) begin
            state_d = S_WDATA;
            cnt_d   = CNT_DATA;
            dout_d  = tx_msb;
            tx_d    = tx_q << 1;
          end else begin
            state_d = S_TURN;
            cnt_d   = CNT_TURN;
            oe_d    = 1'b0;
            dout_d  = 1'b0;
          end
        end
      end
      S_WDATA: begin
        if (fall) begin
          if (!cnt_zero) begin
            cnt_d  = cnt_q - CNT_BITS'(1);
            dout_d = tx_msb;
            tx_d   = tx_q << 1;
          end else begin
`ifdef THREEWIRE_MC_PARITY_EN
            state_d = S_PARITY;
            dout_d  = tx_msb;
            tx_d    = tx_q << 1;
`else
            state_d = S_HOLD;
            dout_d  = 1'b0;
`endif
          end
        end
      end
      S_TURN: begin
        if (fall) begin
          if (!cnt_zero) begin
            cnt_d = cnt_q - CNT_BITS'(1);
          end else begin
            state_d = S_RDATA;
            cnt_d   = CNT_DATA;
          end
        end
      end
      S_RDATA: begin
        if (rise) rx_d = {rx_q[DATA_BITS-2:0], in_tw_data_i};
        if (fall) begin
          if (!cnt_zero) begin
            cnt_d = cnt_q - CNT_BITS'(1);
          end else begin
`ifdef THREEWIRE_MC_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_HOLD;
`endif
          end
        end
      end
      S_PARITY: begin
`ifdef THREEWIRE_MC_PARITY_EN
        if (rise) par_in_d = in_tw_data_i;
`endif
        if (fall) begin
          state_d = S_HOLD;
          dout_d  = 1'b0;
        end
      end
      S_HOLD: begin
        if (fall) begin
          state_d = S_IDLE;
          cs_d    = '1;
          oe_d    = 1'b0;
          dout_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (mode_q == TW_RD) rd_data_d = rx_q;
`ifdef THREEWIRE_MC_PARITY_EN
          parity_err_d = (mode_q == TW_RD) && (par_in_q != ^rx_q);
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q   <= S_IDLE;
      mode_q    <= TW_RD;
      div_q     <= '0;
      cs_q      <= '1;
      tx_q      <= '0;
      rx_q      <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sel_err_q <= 1'b0;
      dout_q    <= 1'b0;
      oe_q      <= 1'b0;
      rd_data_q <= '0;
`ifdef THREEWIRE_MC_PARITY_EN
      par_in_q     <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      div_q     <= div_d;
      cs_q      <= cs_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sel_err_q <= sel_err_d;
      dout_q    <= dout_d;
      oe_q      <= oe_d;
      rd_data_q <= rd_data_d;
`ifdef THREEWIRE_MC_PARITY_EN
      par_in_q     <= par_in_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign host.out_rd_data = rd_data_q;
  assign host.out_busy    = busy_q;
  assign host.out_done    = done_q;
  assign host.out_sel_err = sel_err_q;
  assign out_tw_cs        = cs_q;
  assign out_tw_data_o    = dout_q;
  assign out_tw_data_oe   = oe_q;
`ifdef THREEWIRE_MC_PARITY_EN
  assign out_parity_err   = parity_err_q;
`endif

endmodule

// File: tb/tb_threewire_mc.sv
// Randomized frame-level bench for threewire_mc against a bit-stream model.
// NUM_CS=3 so an out-of-range chip select is encodable in 2 bits.
module tb_threewire_mc;

  localparam int A   = 9;
  localparam int D   = 16;
  localparam int NCS = 3;
  localparam int SB  = 2;
  localparam int DB  = 8;
  localparam int TA  = 1;
`ifdef THREEWIRE_MC_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  threewire_mc_if #(
    .ADDR_BITS (A),
    .DATA_BITS (D),
    .NUM_CS    (NCS),
    .DIV_BITS  (DB)
  ) hif ();

  logic           tw_clk;
  logic [NCS-1:0] tw_cs;
  logic           tw_do;
  logic           tw_oe;
  logic           tw_di = 1'b0;
`ifdef THREEWIRE_MC_PARITY_EN
  logic           perr;
`endif

  threewire_mc #(
    .ADDR_BITS  (A),
    .DATA_BITS  (D),
    .NUM_CS     (NCS),
    .DIV_BITS   (DB),
    .TURNAROUND (TA)
  ) dut (
    .in_clk         (clk),
    .in_rst         (rst),
    .host           (hif),
    .out_tw_clock   (tw_clk),
    .out_tw_cs      (tw_cs),
    .out_tw_data_o  (tw_do),
    .out_tw_data_oe (tw_oe),
`ifdef THREEWIRE_MC_PARITY_EN
    .out_parity_err (perr),
`endif
    .in_tw_data_i   (tw_di)
  );

  int checks = 0;
  int errors = 0;
  logic [D-1:0] rd_model = '0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // bit the slave presents for rising edge k (k=0 is the RW bit)
  function automatic logic slave_bit(int k, logic [D-1:0] sd, logic badp);
    int j;
    j = k - (1 + A + TA);
    if (j >= 0 && j < D) return sd[D-1-j];
    if (j == D) return (^sd) ^ badp;
    return 1'b0;
  endfunction

  task automatic run_frame(logic mode, int sel, logic [A-1:0] addr,
                           logic [D-1:0] wd, logic [DB-1:0] div,
                           logic [D-1:0] sd, logic badp, int inj);
    int t, n, exp_done, nrise, nmaster;
    int k, cyc, bad_cs, bad_oe, bad_rd, done_cyc;
    logic [63:0] expv, gotv;
    logic prev;
    logic [NCS-1:0] cs_exp;
    t        = 2 * (int'(div) + 1);
    n        = A + D + 3 + PB + (mode ? 0 : TA);
    exp_done = n * t + 1;
    nrise    = 1 + A + D + PB + (mode ? 0 : TA);
    nmaster  = mode ? nrise : 1 + A;
    cs_exp   = ~(NCS'(1) << sel);
    expv = 64'(mode);
    for (int i = 0; i < A; i++) expv = {expv[62:0], addr[A-1-i]};
    if (mode) begin
      for (int i = 0; i < D; i++) expv = {expv[62:0], wd[D-1-i]};
      if (PB == 1) expv = {expv[62:0], ^{mode, addr, wd}};
    end
    gotv = '0; k = 0; bad_cs = 0; bad_oe = 0; bad_rd = 0;
    done_cyc = -1; prev = 1'b0;
    tw_di = slave_bit(0, sd, badp);
    @(negedge clk);
    hif.in_start   = 1'b1;
    hif.in_mode_wr = mode;
    hif.in_cs_sel  = SB'(sel);
    hif.in_addr    = addr;
    hif.in_wr_data = wd;
    hif.in_div     = div;
    @(posedge clk); #1;
    hif.in_start   = 1'b0;
    hif.in_mode_wr = 1'($urandom);
    hif.in_cs_sel  = SB'($urandom);
    hif.in_addr    = A'($urandom);
    hif.in_wr_data = D'($urandom);
    hif.in_div     = DB'($urandom);
    cyc = 1;
    while (cyc <= exp_done + 20) begin
      if (cyc == inj) begin
        hif.in_start   = 1'b1;
        hif.in_cs_sel  = SB'(sel);
        hif.in_addr    = ~addr;
        hif.in_mode_wr = ~mode;
      end else begin
        hif.in_start = 1'b0;
      end
      if (hif.out_done) begin
        done_cyc = cyc;
        break;
      end
      if (!hif.out_busy || tw_cs !== cs_exp) bad_cs++;
      if (hif.out_rd_data !== rd_model) bad_rd++;
      if (tw_clk && !prev) begin
        if (k < nmaster) gotv = {gotv[62:0], tw_do};
        if (tw_oe !== (k < nmaster)) bad_oe++;
        k++;
        tw_di = slave_bit(k, sd, badp);
      end
      prev = tw_clk;
      @(posedge clk); #1;
      cyc++;
    end
    hif.in_start = 1'b0;
    if (!mode) rd_model = sd;
    chk("done_cycle", 64'(done_cyc), 64'(exp_done));
    chk("tx_bits", gotv, expv);
    chk("rises", 64'(k), 64'(nrise));
    chk("oe_per_bit", 64'(bad_oe), 64'd0);
    chk("cs_busy", 64'(bad_cs), 64'd0);
    chk("rd_stable", 64'(bad_rd), 64'd0);
    chk("rd_data", 64'(hif.out_rd_data), 64'(rd_model));
    chk("end_state", {tw_cs, hif.out_busy, tw_oe, tw_clk},
        {{NCS{1'b1}}, 3'b000});
`ifdef THREEWIRE_MC_PARITY_EN
    chk("parity_err", 64'(perr), 64'(!mode && badp));
`endif
    @(posedge clk); #1;
    chk("done_pulse", 64'(hif.out_done), 64'd0);
  endtask

  initial begin
    int c, k;
    logic prev;
    hif.in_start   = 1'b0;
    hif.in_mode_wr = 1'b0;
    hif.in_cs_sel  = '0;
    hif.in_addr    = '0;
    hif.in_wr_data = '0;
    hif.in_div     = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_state", {tw_cs, hif.out_busy, hif.out_done,
                      hif.out_sel_err, tw_clk, tw_oe, tw_do},
        {{NCS{1'b1}}, 6'b0});
    chk("rst_rd_data", 64'(hif.out_rd_data), 64'd0);

    run_frame(1'b1, 2, 9'h1A5, 16'hBEEF, 8'd0, 16'h0, 1'b0, 0);
    run_frame(1'b0, 0, 9'h003, 16'h0, 8'd3, 16'h1234, 1'b0, 0);
    run_frame(1'b0, 1, 9'h0F0, 16'h0, 8'd1, 16'hA5C3, 1'b1, 0);
    run_frame(1'b1, 1, 9'h155, 16'h1357, 8'd2, 16'h0, 1'b0, 20);

    // out-of-range chip select
    @(negedge clk);
    hif.in_start  = 1'b1;
    hif.in_cs_sel = SB'(3);
    @(posedge clk); #1;
    hif.in_start = 1'b0;
    chk("sel_err_pulse", {hif.out_sel_err, hif.out_busy, tw_cs},
        {2'b10, {NCS{1'b1}}});
    @(posedge clk); #1;
    chk("sel_err_clear", {hif.out_sel_err, hif.out_busy}, 2'b00);

    // reset in the middle of the address phase
    @(negedge clk);
    hif.in_start   = 1'b1;
    hif.in_mode_wr = 1'b1;
    hif.in_cs_sel  = SB'(1);
    hif.in_div     = 8'd1;
    @(posedge clk); #1;
    hif.in_start = 1'b0;
    k = 0; c = 0; prev = 1'b0;
    while (k < 4 && c < 500) begin
      if (tw_clk && !prev) k++;
      prev = tw_clk;
      @(posedge clk); #1;
      c++;
    end
    chk("reach_addr", 64'(k), 64'd4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst", {tw_cs, tw_clk, tw_oe, hif.out_busy, hif.out_done},
        {{NCS{1'b1}}, 4'b0});
    c = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (hif.out_done || hif.out_busy) c++;
    end
    chk("no_done_after_rst", 64'(c), 64'd0);
    rd_model = '0;
    run_frame(1'b0, 2, 9'h1FF, 16'h0, 8'd0, 16'h8001, 1'b0, 0);

    for (int i = 0; i < 10; i++) begin
      run_frame(1'($urandom), int'($urandom_range(0, NCS - 1)),
                A'($urandom), D'($urandom),
                DB'($urandom_range(0, 4)), D'($urandom),
                1'($urandom), (i % 3 == 0) ? 15 : 0);
    end
    run_frame(1'b0, 0, A'($urandom), 16'h0, 8'hFF,
              D'($urandom), 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
